// File: rtl/image_checker_if.sv
// rtl/image_checker_if.sv - pixel/golden memory read bus for image_checker
// The checker drives the read strobe and address; memory returns pixel and golden data one cycle later.
interface image_checker_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 16
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic [PIX_W-1:0]  gold_data;

  modport master (output rd_en, rd_addr, input rd_data, gold_data);
  modport slave  (input rd_en, rd_addr, output rd_data, gold_data);
endinterface

// File: rtl/image_checker.sv
// rtl/image_checker.sv - frame scanner comparing each output pixel against a constant, golden port or range
// Issues one read per cycle and compares one cycle later; reports pass, saturating mismatch count and first failing pixel.
module image_checker #(
  parameter int PIX_W     = 8,
  parameter int IMG_W     = 256,
  parameter int IMG_H     = 256,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0,
  parameter int CNT_W     = 17,
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [PIX_W-1:0]  exp_lo,
  input  logic [PIX_W-1:0]  exp_hi,
  image_checker_if.master   mem,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic              first_err_valid,
  output logic [XW-1:0]     first_err_x,
  output logic [YW-1:0]     first_err_y
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] MODE_GOLDEN = 2'b01;
  localparam logic [1:0] MODE_RANGE  = 2'b10;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              cmp_valid_q, cmp_valid_d;
  logic [XW-1:0]     cmp_x_q, cmp_x_d;
  logic [YW-1:0]     cmp_y_q, cmp_y_d;
  logic [1:0]        mode_q, mode_d;
  logic [PIX_W-1:0]  lo_q, lo_d;
  logic [PIX_W-1:0]  hi_q, hi_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              fev_q, fev_d;
  logic [XW-1:0]     fex_q, fex_d;
  logic [YW-1:0]     fey_q, fey_d;
  logic              pass_q, pass_d;

  logic last_issue;
  logic mismatch;

  assign last_issue = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));

  // Reserved mode 11 falls into the CONST branch
  always_comb begin
    mismatch = 1'b0;
    case (mode_q)
      MODE_GOLDEN: mismatch = (mem.rd_data != mem.gold_data);
      MODE_RANGE:  mismatch = !((lo_q <= mem.rd_data) && (mem.rd_data <= hi_q));
      default:     mismatch = (mem.rd_data != lo_q);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    x_d         = x_q;
    y_d         = y_q;
    cmp_valid_d = (state_q == ST_SCAN);
    cmp_x_d     = x_q;
    cmp_y_d     = y_q;
    mode_d      = mode_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    err_d       = err_q;
    fev_d       = fev_q;
    fex_d       = fex_q;
    fey_d       = fey_q;
    pass_d      = pass_q;

    if (abort) begin
      state_d     = ST_IDLE;
      cmp_valid_d = 1'b0;
    end else begin
      if (cmp_valid_q && mismatch) begin
        if (err_q != {CNT_W{1'b1}}) begin
          err_d = err_q + CNT_W'(1);
        end
        if (!fev_q) begin
          fev_d = 1'b1;
          fex_d = cmp_x_q;
          fey_d = cmp_y_q;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_SCAN;
            mode_d  = mode;
            lo_d    = exp_lo;
            hi_d    = exp_hi;
            err_d   = '0;
            fev_d   = 1'b0;
            fex_d   = '0;
            fey_d   = '0;
            pass_d  = 1'b0;
            addr_d  = ADDR_W'(BASE_ADDR);
            x_d     = '0;
            y_d     = '0;
          end
        end
        ST_SCAN: begin
          if (last_issue) begin
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (x_q == XW'(IMG_W - 1)) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
        ST_DRAIN: begin
          // err_d already includes the last pixel, so pass is final in the done cycle
          state_d = ST_DONE;
          pass_d  = (err_d == '0);
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= ADDR_W'(BASE_ADDR);
      x_q         <= '0;
      y_q         <= '0;
      cmp_valid_q <= 1'b0;
      cmp_x_q     <= '0;
      cmp_y_q     <= '0;
      mode_q      <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      err_q       <= '0;
      fev_q       <= 1'b0;
      fex_q       <= '0;
      fey_q       <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_x_q     <= cmp_x_d;
      cmp_y_q     <= cmp_y_d;
      mode_q      <= mode_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      err_q       <= err_d;
      fev_q       <= fev_d;
      fex_q       <= fex_d;
      fey_q       <= fey_d;
      pass_q      <= pass_d;
    end
  end

  assign mem.rd_en       = (state_q == ST_SCAN);
  assign mem.rd_addr     = addr_q;
  assign busy            = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
  assign done            = (state_q == ST_DONE);
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_x     = fex_q;
  assign first_err_y     = fey_q;

endmodule

// File: tb/tb_image_checker.sv
// tb/tb_image_checker.sv - scoreboard bench for image_checker on an 8x4 frame at base address 16
// A main DUT (17-bit counter) and a 3-bit-counter twin see identical stimulus and memory.
module tb_image_checker;

  localparam int BASE = 16;
  localparam int NPIX = 32;

  typedef struct {
    int err;
    int fev;
    int fx;
    int fy;
    int pass;
    int err3;
    int t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] exp_lo = 8'd0;
  logic [7:0] exp_hi = 8'd0;

  logic        busy, done, pass, fev;
  logic [16:0] err_count;
  logic [2:0]  fx;
  logic [1:0]  fy;
  logic        d2_busy, d2_done, d2_pass, d2_fev;
  logic [2:0]  d2_err;
  logic [2:0]  d2_fx;
  logic [1:0]  d2_fy;

  logic [7:0] mem   [NPIX];
  logic [7:0] gold  [NPIX];
  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         addr_idx = 0;
  int         ridx;

  image_checker_if #(.PIX_W(8), .ADDR_W(8)) bus ();
  image_checker_if #(.PIX_W(8), .ADDR_W(8)) bus3 ();

  image_checker #(.PIX_W(8), .IMG_W(8), .IMG_H(4), .ADDR_W(8), .BASE_ADDR(BASE), .CNT_W(17)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .exp_lo(exp_lo), .exp_hi(exp_hi), .mem(bus.master),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_valid(fev), .first_err_x(fx), .first_err_y(fy)
  );

  image_checker #(.PIX_W(8), .IMG_W(8), .IMG_H(4), .ADDR_W(8), .BASE_ADDR(BASE), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .exp_lo(exp_lo), .exp_hi(exp_hi), .mem(bus3.master),
    .busy(d2_busy), .done(d2_done), .pass(d2_pass), .err_count(d2_err),
    .first_err_valid(d2_fev), .first_err_x(d2_fx), .first_err_y(d2_fy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    ridx = int'(bus.rd_addr) - BASE;
    if (bus.rd_en && ridx >= 0 && ridx < NPIX) begin
      bus.rd_data   <= mem[ridx];
      bus.gold_data <= gold[ridx];
    end
  end
  assign bus3.rd_data   = bus.rd_data;
  assign bus3.gold_data = bus.gold_data;

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Monitor: address stream checked every issue cycle, results popped on each done
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc - e.t0, NPIX + 2);
        chk("busy_in_done", int'(busy), 0);
        chk("addr_count", addr_idx, NPIX);
        chk("err_count", int'(err_count), e.err);
        chk("first_err_valid", int'(fev), e.fev);
        chk("first_err_x", int'(fx), e.fx);
        chk("first_err_y", int'(fy), e.fy);
        chk("pass", int'(pass), e.pass);
        chk("err_count_sat", int'(d2_err), e.err3);
        chk("done_twin", int'(d2_done), 1);
      end
    end
    if (bus.rd_en) begin
      chk("rd_addr", int'(bus.rd_addr), BASE + addr_idx);
      addr_idx++;
    end
    if (!busy) addr_idx = 0;
  end

  task automatic issue(input logic [1:0] m, input logic [7:0] lo, input logic [7:0] hi,
                       input bit push, input int err, input int fe, input int x, input int y);
    exp_t e;
    @(negedge clk);
    mode = m;
    exp_lo = lo;
    exp_hi = hi;
    start = 1'b1;
    if (push) begin
      e.err = err; e.fev = fe; e.fx = x; e.fy = y;
      e.pass = (err == 0) ? 1 : 0;
      e.err3 = (err > 7) ? 7 : err;
      e.t0 = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_rd_en", int'(bus.rd_en), 0);
    chk("rst_rd_addr", int'(bus.rd_addr), BASE);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_fev", int'(fev), 0);
    chk("rst_fx", int'(fx), 0);
    chk("rst_fy", int'(fy), 0);
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < NPIX; i++) begin
      mem[i] = v;
      gold[i] = v;
    end
  endtask

  initial begin
    bus.rd_data = 8'd0;
    bus.gold_data = 8'd0;
    fill_const(8'd96);
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;

    // CONST, clean frame; a stray start mid-scan must not restart it
    issue(2'b00, 8'd96, 8'd0, 1, 0, 0, 0, 0);
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sb();

    // CONST with two wrong pixels, (3,2) and (5,3)
    mem[2*8+3] = 8'd7;
    mem[3*8+5] = 8'd0;
    issue(2'b00, 8'd96, 8'd0, 1, 2, 1, 3, 2);
    wait_sb();

    // GOLDEN differing only at the last address
    for (int i = 0; i < NPIX; i++) begin
      mem[i] = 8'(i * 5);
      gold[i] = 8'(i * 5);
    end
    gold[31] = mem[31] ^ 8'h01;
    issue(2'b01, 8'd0, 8'd0, 1, 1, 1, 7, 3);
    wait_sb();

    // RANGE 10..20 on a 9/10/20/21 pattern, then an inverted range
    for (int i = 0; i < NPIX; i++) begin
      case (i % 4)
        0: mem[i] = 8'd9;
        1: mem[i] = 8'd10;
        2: mem[i] = 8'd20;
        default: mem[i] = 8'd21;
      endcase
    end
    issue(2'b10, 8'd10, 8'd20, 1, 16, 1, 0, 0);
    wait_sb();
    issue(2'b10, 8'd30, 8'd20, 1, 32, 1, 0, 0);
    wait_sb();

    // rst at cycle 10 of a scan
    fill_const(8'd96);
    issue(2'b00, 8'd96, 8'd0, 0, 0, 0, 0, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals();
    rst = 1'b0;

    // abort at cycle 5, then abort racing start in IDLE
    issue(2'b00, 8'd96, 8'd0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_pass", int'(pass), 0);
    abort = 1'b1;
    issue(2'b00, 8'd96, 8'd0, 0, 0, 0, 0, 0);
    abort = 1'b0;
    chk("abort_start_busy", int'(busy), 0);
    repeat (45) @(negedge clk);

    // fresh scan after abort, reserved mode behaves as CONST
    issue(2'b11, 8'd96, 8'd0, 1, 0, 0, 0, 0);
    wait_sb();
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
